// File: rtl/lsu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_pkg : shared constants and types for load_store_unit   rev 1.0
// ------------------------------------------------------------------
package lsu_pkg;

  localparam int LSU_WIDTH     = 32;
  localparam int LSU_MEM_WORDS = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ------------------------------------------------------------------
// lsu_align : load extract/extend and sub-word store merge   rev 1.0
// ------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = LSU_WIDTH
) (
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       byte_off_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] load_o,
  output logic [WIDTH-1:0] store_o
);

  logic [4:0]       sh_b;
  logic [4:0]       sh_h;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic [WIDTH-1:0] mask;

  assign sh_b  = {byte_off_i, 3'b000};
  assign sh_h  = {byte_off_i[1], 4'b0000};
  assign sel_b = rdata_i[sh_b +: 8];
  assign sel_h = rdata_i[sh_h +: 16];

  always_comb begin
    load_o = rdata_i;
    case (funct3_i)
      F3_B:    load_o = {{(WIDTH-8){sel_b[7]}}, sel_b};
      F3_H:    load_o = {{(WIDTH-16){sel_h[15]}}, sel_h};
      F3_BU:   load_o = {{(WIDTH-8){1'b0}}, sel_b};
      F3_HU:   load_o = {{(WIDTH-16){1'b0}}, sel_h};
      default: load_o = rdata_i;
    endcase
  end

  // funct3[0] distinguishes SH from SB; the mask marks the lanes being replaced.
  assign mask    = funct3_i[0] ? ({{(WIDTH-16){1'b0}}, 16'hFFFF} << sh_h)
                               : ({{(WIDTH-8){1'b0}}, 8'hFF} << sh_b);
  assign store_o = (rdata_i & ~mask) |
                   ((wdata_i << (funct3_i[0] ? sh_h : sh_b)) & mask);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// load_store_unit : single-port RISC-V load/store FSM        rev 1.0
// ------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH     = LSU_WIDTH,
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] READ  = S_READ;
  localparam logic [2:0] MERGE = S_MERGE;
  localparam logic [2:0] WRITE = S_WRITE;
  localparam logic [2:0] RESP  = S_RESP;

  logic [2:0]       state_q, state_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q, wdata_q, wbuf_q, rdata_q;
  logic             err_q;
  logic             fault, misal, oob, accept;
  logic [WIDTH-1:0] load_val, merged;

  assign misal  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign oob    = {2'b00, req_addr[WIDTH-1:2]} >= WIDTH'(MEM_WORDS);
  assign fault  = !f3_legal(req_we, req_funct3) || misal || oob;
  assign accept = (state_q == IDLE) && req_valid;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3_i   (f3_q),
    .byte_off_i (addr_q[1:0]),
    .rdata_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .store_o    (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault)                              state_d = RESP;
          else if (req_we && req_funct3 == F3_W)  state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ:    state_d = MERGE;
      MERGE:   state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers only change on the edge entering RESP, so they hold
  // the previous result for the whole duration of the next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (fault) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == MERGE) begin
        if (we_q) begin
          wbuf_q <= merged;
        end else begin
          rdata_q <= load_val;
          err_q   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wr     = (state_q == WRITE);
  assign mem_addr   = (state_q == IDLE) ? '0 : {2'b00, addr_q[WIDTH-1:2]};
  assign mem_wdata  = (state_q == WRITE) ? ((f3_q == F3_W) ? wdata_q : wbuf_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_load_store_unit : randomized + directed bench for LSU   rev 1.0
// ------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  logic [31:0] mem [0:1023];
  logic        poke_en;
  logic [9:0]  poke_addr;
  logic [31:0] poke_data;

  logic [7:0]  rbytes [0:4095];

  int          ncmp, nfail;
  int          o_lat, o_wr, o_busy;
  logic [31:0] o_rd;
  logic        o_err;

  load_store_unit #(.WIDTH(32), .MEM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en)     mem[poke_addr] <= poke_data;
    else if (mem_wr) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic poke(input int w, input logic [31:0] v);
    logic [9:0] wa;
    wa = w[9:0];
    @(negedge clk);
    poke_en = 1'b1; poke_addr = wa; poke_data = v;
    @(negedge clk);
    poke_en = 1'b0;
    for (int b = 0; b < 4; b++) rbytes[w*4+b] = v[8*b +: 8];
  endtask

  // Byte-addressed reference: legality, little-endian value, latency.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err, output int lat);
    int   n;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n     = 1 << f3[1:0];
    err   = !legal || ((a % n) != 0) || (a >= 32'd4096);
    rd    = 32'd0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) rbytes[a+i] = wd[8*i +: 8];
      lat = (n == 4) ? 2 : 4;
    end else begin
      for (int i = n - 1; i >= 0; i--) rd = (rd << 8) | {24'd0, rbytes[a+i]};
      if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      lat = 3;
    end
  endfunction

  function automatic logic [31:0] rword(input int w);
    return {rbytes[w*4+3], rbytes[w*4+2], rbytes[w*4+1], rbytes[w*4]};
  endfunction

  // Drives one request and records what the DUT did until resp_valid.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    o_lat = 0; o_wr = 0; o_busy = 0; o_rd = 'x; o_err = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      if (mem_wr) o_wr++;
      if (req_ready) o_busy++;
      if (resp_valid) begin
        o_lat = c; o_rd = resp_rdata; o_err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
    ncmp++; if (mem_wr !== 1'b0) begin nfail++; $display("FAIL rst_memwr: got %b want 0", mem_wr); end
    ncmp++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin nfail++; $display("FAIL rst_resp: got %h/%b want 0/0", resp_rdata, resp_err); end
    ncmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin nfail++; $display("FAIL rst_membus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    ncmp++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_load;
    poke(5, 32'h8899_AABB);
    issue(1'b0, 3'b000, 32'h15, 32'd0);
    ncmp++; if (o_rd !== 32'hFFFF_FFAA) begin nfail++; $display("FAIL lb_data: got %h want ffffffaa", o_rd); end
    ncmp++; if (o_err !== 1'b0) begin nfail++; $display("FAIL lb_err: got %b want 0", o_err); end
    ncmp++; if (o_lat !== 3) begin nfail++; $display("FAIL lb_lat: got %0d want 3", o_lat); end
    issue(1'b0, 3'b101, 32'h16, 32'd0);
    ncmp++; if (o_rd !== 32'h0000_8899) begin nfail++; $display("FAIL lhu_data: got %h want 00008899", o_rd); end
  endtask

  task automatic test_store_byte;
    poke(5, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h17, 32'h0000_00CC);
    ncmp++; if (mem[5] !== 32'hCC22_3344) begin nfail++; $display("FAIL sb_mem: got %h want cc223344", mem[5]); end
    ncmp++; if (o_wr !== 1) begin nfail++; $display("FAIL sb_wrcount: got %0d want 1", o_wr); end
    ncmp++; if (o_lat !== 4) begin nfail++; $display("FAIL sb_lat: got %0d want 4", o_lat); end
    ncmp++; if (o_rd !== 32'd0 || o_err !== 1'b0) begin nfail++; $display("FAIL sb_resp: got %h/%b want 0/0", o_rd, o_err); end
  endtask

  task automatic test_faults;
    issue(1'b0, 3'b010, 32'h0000_0006, 32'd0);
    ncmp++; if (o_err !== 1'b1 || o_lat !== 1) begin nfail++; $display("FAIL f_misal: got err=%b lat=%0d want 1/1", o_err, o_lat); end
    ncmp++; if (o_wr !== 0) begin nfail++; $display("FAIL f_misal_wr: got %0d want 0", o_wr); end
    issue(1'b1, 3'b010, 32'h0000_1000, 32'h1234_5678);
    ncmp++; if (o_err !== 1'b1 || o_wr !== 0) begin nfail++; $display("FAIL f_range: got err=%b wr=%0d want 1/0", o_err, o_wr); end
    issue(1'b0, 3'b011, 32'h0000_0008, 32'd0);
    ncmp++; if (o_err !== 1'b1 || o_rd !== 32'd0) begin nfail++; $display("FAIL f_funct3: got err=%b rd=%h want 1/0", o_err, o_rd); end
  endtask

  task automatic test_reset_mid;
    int wr, rv;
    poke(5, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h16; req_wdata = 32'h5566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    ncmp++; if (mem_wr !== 1'b0 || resp_valid !== 1'b0) begin nfail++; $display("FAIL mid_rst_out: got wr=%b rv=%b want 0/0", mem_wr, resp_valid); end
    ncmp++; if (resp_rdata !== 32'd0 || req_ready !== 1'b1) begin nfail++; $display("FAIL mid_rst_state: got rd=%h rdy=%b want 0/1", resp_rdata, req_ready); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    wr = 0; rv = 0;
    ncmp++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (mem_wr) wr++;
      if (resp_valid) rv++;
    end
    ncmp++; if (wr !== 0 || rv !== 0) begin nfail++; $display("FAIL mid_rst_quiet: got wr=%0d rv=%0d want 0/0", wr, rv); end
    ncmp++; if (mem[5] !== 32'h1122_3344) begin nfail++; $display("FAIL mid_rst_mem: got %h want 11223344", mem[5]); end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    ncmp++; if (o_lat !== 2 || o_busy !== 0) begin nfail++; $display("FAIL b2b_sw: got lat=%0d busy_ready=%0d want 2/0", o_lat, o_busy); end
    issue(1'b0, 3'b010, 32'h0, 32'd0);
    ncmp++; if (o_rd !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL b2b_lw: got %h want deadbeef", o_rd); end
    ncmp++; if (o_busy !== 0) begin nfail++; $display("FAIL b2b_ready: got %0d ready cycles want 0", o_busy); end
  endtask

  task automatic test_random;
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd;
    int          e_lat;
    for (int w = 0; w < 16; w++) poke(w, $urandom);
    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
      else                          a = 32'd4096 + $urandom_range(0, 1 << 20);
      model(we, f3, a, wd, e_rd, e_err, e_lat);
      issue(we, f3, a, wd);
      ncmp++; if (o_lat !== e_lat) begin nfail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", it, o_lat, e_lat); end
      ncmp++; if (o_err !== e_err) begin nfail++; $display("FAIL rnd_err[%0d]: got %b want %b", it, o_err, e_err); end
      ncmp++; if (o_rd !== e_rd) begin nfail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, o_rd, e_rd); end
      ncmp++; if (o_wr !== ((we && !e_err) ? 1 : 0)) begin nfail++; $display("FAIL rnd_wr[%0d]: got %0d want %0d", it, o_wr, (we && !e_err) ? 1 : 0); end
      if (we && !e_err) begin
        ncmp++; if (mem[a[11:2]] !== rword(int'(a[11:2]))) begin nfail++; $display("FAIL rnd_mem[%0d]: got %h want %h", it, mem[a[11:2]], rword(int'(a[11:2]))); end
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    model(1'b0, 3'b010, 32'h8, 32'd0, e_rd, e_err, e_lat);
    issue(1'b0, 3'b010, 32'h8, 32'd0);
    @(posedge clk); #1;
    ncmp++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL hold_pulse: got %b want 0", resp_valid); end
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (resp_rdata !== e_rd || resp_err !== 1'b0) begin nfail++; $display("FAIL hold_data: got %h/%b want %h/0", resp_rdata, resp_err, e_rd); end
    ncmp++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin nfail++; $display("FAIL idle_membus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    issue(1'b1, 3'b001, 32'h3, 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin nfail++; $display("FAIL hold_err: got %b/%h want 1/0", resp_err, resp_rdata); end
  endtask

  initial begin
    ncmp = 0; nfail = 0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    poke_en = 1'b0; poke_addr = 10'd0; poke_data = 32'd0;
    for (int i = 0; i < 4096; i++) rbytes[i] = 8'd0;
    test_reset;
    test_load;
    test_store_byte;
    test_faults;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter MEM_WORDS, default 1024, number of words in the attached data memory.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  pipeline presents a load/store request.
REQ-006 req_ready  output  1  unit accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 size/sign code.
REQ-009 req_addr  input  WIDTH  byte address.
REQ-010 req_wdata  input  WIDTH  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  WIDTH  formatted load result; 0 for stores and faults.
REQ-013 resp_err  output  1  misaligned, out-of-range or illegal-funct3 request; qualified by resp_valid.
REQ-014 mem_addr  output  WIDTH  word index to the data memory, {2'b00, addr[WIDTH-1:2]}.
REQ-015 mem_wr  output  1  memory write strobe; 0 = read.
REQ-016 mem_wdata  output  WIDTH  word to write.
REQ-017 mem_rdata  input  WIDTH  memory read data, valid the cycle after the read address was presented with mem_wr=0.

Function
REQ-018 FSM states SHALL be IDLE, READ, MERGE, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE with req_valid=1, the unit SHALL latch we, funct3, addr and wdata, then go to:
- RESP with resp_err=1 on a fault;
- WRITE for SW;
- READ for every other legal request.
REQ-020 Legal loads SHALL be LB=000, LH=001, LW=010, LBU=100 and LHU=101; legal stores SHALL be SB=000, SH=001 and SW=010; any other funct3 SHALL be a fault.
REQ-021 A halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be a fault.
REQ-022 An access with addr[WIDTH-1:2] >= MEM_WORDS SHALL be a fault.
REQ-023 A faulting request SHALL never assert mem_wr.
REQ-024 READ SHALL drive mem_addr with mem_wr=0 for one cycle, then go to MERGE.
REQ-025 In MERGE, a load SHALL register its result from mem_rdata and go to RESP.
- The byte or half is selected by addr[1:0], little-endian.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
REQ-026 In MERGE, SB/SH SHALL register the merged word into the write buffer and go to WRITE.
- The merged word is mem_rdata with the addressed byte or half replaced by req_wdata[7:0] or [15:0].
- All other bytes are unchanged.
REQ-027 WRITE SHALL assert mem_wr=1 for exactly one cycle, then go to RESP.
- mem_addr is the latched word index.
- mem_wdata is the write buffer (SB/SH) or the latched wdata (SW).
REQ-028 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-029 Latency from the accept cycle to resp_valid SHALL be:
- 3 cycles for loads;
- 4 cycles for SB/SH;
- 2 cycles for SW;
- 1 cycle for faults.
REQ-030 resp_rdata and resp_err SHALL hold their values until the next request completes.
REQ-031 mem_wr SHALL be a pure decode of state==WRITE and SHALL be 0 in every other state.
REQ-032 mem_addr and mem_wdata SHALL be 0 in IDLE.

Reset
REQ-033 Asserting reset SHALL immediately force:
- state=IDLE, mem_wr=0, resp_valid=0;
- resp_rdata=0, resp_err=0;
- the write buffer and latched request to 0.
REQ-034 Reset asserted mid-operation SHALL abandon the access with no response. If it is asserted before the WRITE-cycle edge, no memory write SHALL occur.
REQ-035 After reset deasserts, req_ready SHALL be 1 in the first cycle.

Structure
REQ-036 Package lsu_pkg SHALL hold the funct3 load/store constants, the FSM state enum and the default WIDTH and MEM_WORDS.
REQ-037 Sub-module lsu_align (combinational) SHALL implement load extraction/extension and store-merge; the FSM SHALL remain in load_store_unit.

Verification
REQ-038 Memory word 5 = 0x8899AABB; LB at addr 0x15 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 3 cycles after accept.
REQ-039 Memory word 5 = 0x8899AABB; LHU at addr 0x16 -> resp_rdata=0x00008899.
REQ-040 SB wdata=0x000000CC at addr 0x17 over 0x11223344:
- memory word 5 becomes 0xCC223344;
- exactly one mem_wr pulse;
- resp_valid 4 cycles after accept.
REQ-041 Faults:
- LW at 0x0000_0006 -> resp_err=1 one cycle after accept, no mem_wr;
- SW at 0x0000_1000 (word 1024) -> resp_err=1;
- funct3=011 load -> resp_err=1.
REQ-042 SH started, then reset asserted during MERGE -> memory unchanged, no resp_valid, req_ready=1 after release.
REQ-043 Back-to-back SW 0xDEADBEEF to addr 0 then LW from addr 0 -> resp_rdata=0xDEADBEEF; req_ready low throughout each operation.
